ps2_key_event_ctrl: RTL and testbench

//   Sequencer behind the PS/2 byte receiver (RX_DATA/DATA_VALID).

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_key_event_ctrl_if.sv | 30 +++
 rtl/ps2_evt_fifo.sv | 55 +++++
 rtl/ps2_key_event_ctrl.sv | 142 ++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } ps2_state_t;

    // Event record is packed as {ext, brk, code}.
    function automatic int evt_width(input int dp_size);
        return dp_size + 2;
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out bus of the PS/2 key event controller.
interface ps2_key_event_ctrl_if #(
    parameter int DP_size    = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DP_size-1:0] RX_DATA;
    logic               DATA_VALID;
    logic               EVT_VALID;
    logic               EVT_READY;
    logic [DP_size-1:0] EVT_CODE;
    logic               EVT_EXT;
    logic               EVT_BREAK;
    logic [CNT_W-1:0]   FIFO_COUNT;
    logic               OVERFLOW;
    logic               CLR_OVF;
    logic               SEQ_ERR;

    modport master (
        output RX_DATA, DATA_VALID, EVT_READY, CLR_OVF,
        input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, FIFO_COUNT, OVERFLOW, SEQ_ERR
    );

    modport slave (
        input  RX_DATA, DATA_VALID, EVT_READY, CLR_OVF,
        output EVT_VALID, EVT_CODE, EVT_EXT, EVT_BREAK, FIFO_COUNT, OVERFLOW, SEQ_ERR
    );

endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO for key events; push while full is dropped
// unless a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: prefix parser, inter-byte watchdog, event FIFO.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | no prefix pending; plain byte is a make event
//   GOT_E0   | extended prefix seen
//   GOT_F0   | break prefix seen
//   GOT_E0F0 | extended break prefix seen
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int DP_size        = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic CLOCK,
    input logic RESET,
    ps2_key_event_ctrl_if.slave bus
);

    localparam int EVT_W = evt_width(DP_size);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_t       state_q;
    ps2_state_t       state_nxt;
    logic [WD_W-1:0]  wdog_q;
    logic             push;
    logic [EVT_W-1:0] push_evt;
    logic             seq_err_nxt;
    logic             seq_err_q;
    logic             ovf_q;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EVT_W-1:0] head_evt;
    logic [CNT_W-1:0] fifo_count;
    logic             is_ext;
    logic             is_brk;
    logic             wdog_expired;

    assign is_ext       = (bus.RX_DATA == DP_size'(PS2_EXT));
    assign is_brk       = (bus.RX_DATA == DP_size'(PS2_BRK));
    assign wdog_expired = (state_q != IDLE) && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            seq_err_q <= seq_err_nxt;
        end
    end

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_nxt   = state_q;
        push        = 1'b0;
        push_evt    = {2'b00, bus.RX_DATA};
        seq_err_nxt = 1'b0;
        if (bus.DATA_VALID) begin
            case (state_q)
                IDLE: begin
                    if (is_ext)      state_nxt = GOT_E0;
                    else if (is_brk) state_nxt = GOT_F0;
                    else begin
                        push     = 1'b1;
                        push_evt = {1'b0, 1'b0, bus.RX_DATA};
                    end
                end
                GOT_E0: begin
                    state_nxt = IDLE;
                    if (is_brk)      state_nxt = GOT_E0F0;
                    else if (is_ext) seq_err_nxt = 1'b1;
                    else begin
                        push     = 1'b1;
                        push_evt = {1'b1, 1'b0, bus.RX_DATA};
                    end
                end
                GOT_F0: begin
                    state_nxt = IDLE;
                    if (is_ext || is_brk) seq_err_nxt = 1'b1;
                    else begin
                        push     = 1'b1;
                        push_evt = {1'b0, 1'b1, bus.RX_DATA};
                    end
                end
                GOT_E0F0: begin
                    state_nxt = IDLE;
                    if (is_ext || is_brk) seq_err_nxt = 1'b1;
                    else begin
                        push     = 1'b1;
                        push_evt = {1'b1, 1'b1, bus.RX_DATA};
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (wdog_expired) begin
            state_nxt   = IDLE;
            seq_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || bus.DATA_VALID || state_q == IDLE) wdog_q <= '0;
        else                                            wdog_q <= wdog_q + 1'b1;
    end

    assign pop = !fifo_empty && bus.EVT_READY;

    always_ff @(posedge CLOCK) begin
        if (RESET)                          ovf_q <= 1'b0;
        else if (push && fifo_full && !pop) ovf_q <= 1'b1;
        else if (bus.CLR_OVF)               ovf_q <= 1'b0;
    end

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .push  (push),
        .wdata (push_evt),
        .pop   (pop),
        .rdata (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Event fields are forced to zero while nothing is buffered.
    assign bus.EVT_VALID  = !fifo_empty;
    assign bus.EVT_EXT    = fifo_empty ? 1'b0 : head_evt[EVT_W-1];
    assign bus.EVT_BREAK  = fifo_empty ? 1'b0 : head_evt[EVT_W-2];
    assign bus.EVT_CODE   = fifo_empty ? '0   : head_evt[DP_size-1:0];
    assign bus.FIFO_COUNT = fifo_count;
    assign bus.OVERFLOW   = ovf_q;
    assign bus.SEQ_ERR    = seq_err_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl with hand-computed expected events.
module tb_ps2_key_event_ctrl;

    localparam int DP    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLOCK = ~CLOCK;

    ps2_key_event_ctrl_if #(.DP_size(DP), .FIFO_DEPTH(DEPTH)) bus ();

    ps2_key_event_ctrl #(
        .DP_size        (DP),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] head();
        return {bus.EVT_EXT, bus.EVT_BREAK, bus.EVT_CODE};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK);
        bus.RX_DATA    = b;
        bus.DATA_VALID = 1'b1;
        @(negedge CLOCK);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] exp);
        check(tag, {22'd0, head()}, {22'd0, exp});
        bus.EVT_READY = 1'b1;
        @(negedge CLOCK);
        bus.EVT_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first_at;

        bus.RX_DATA    = '0;
        bus.DATA_VALID = 1'b0;
        bus.EVT_READY  = 1'b0;
        bus.CLR_OVF    = 1'b0;
        RESET          = 1'b1;
        repeat (3) @(negedge CLOCK);
        check("rst_valid", {31'd0, bus.EVT_VALID}, 32'd0);
        check("rst_code",  {24'd0, bus.EVT_CODE}, 32'd0);
        check("rst_count", {29'd0, bus.FIFO_COUNT}, 32'd0);
        check("rst_ovf",   {31'd0, bus.OVERFLOW}, 32'd0);
        check("rst_err",   {31'd0, bus.SEQ_ERR}, 32'd0);
        RESET = 1'b0;

        // 1: plain make with consumer ready
        bus.EVT_READY = 1'b1;
        send_byte(8'h1C);
        check("t1_valid", {31'd0, bus.EVT_VALID}, 32'd1);
        check("t1_evt",   {22'd0, head()}, {22'd0, 10'b00_0001_1100});
        check("t1_count", {29'd0, bus.FIFO_COUNT}, 32'd1);
        @(negedge CLOCK);
        check("t1_valid_gone", {31'd0, bus.EVT_VALID}, 32'd0);
        check("t1_count_zero", {29'd0, bus.FIFO_COUNT}, 32'd0);

        // 2: extended break
        send_byte(8'hE0);
        check("t2_e0_valid", {31'd0, bus.EVT_VALID}, 32'd0);
        check("t2_e0_err",   {31'd0, bus.SEQ_ERR}, 32'd0);
        send_byte(8'hF0);
        check("t2_f0_valid", {31'd0, bus.EVT_VALID}, 32'd0);
        check("t2_f0_err",   {31'd0, bus.SEQ_ERR}, 32'd0);
        send_byte(8'h75);
        check("t2_valid", {31'd0, bus.EVT_VALID}, 32'd1);
        check("t2_evt",   {22'd0, head()}, {22'd0, 2'b11, 8'h75});
        @(negedge CLOCK);
        check("t2_single", {29'd0, bus.FIFO_COUNT}, 32'd0);

        // 3: break prefix then silence -> timeout
        send_byte(8'hF0);
        pulses   = 0;
        first_at = -1;
        for (int i = 1; i <= TMO + 8; i++) begin
            @(negedge CLOCK);
            if (bus.SEQ_ERR) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("t3_err_cycle",  first_at, TMO);
        check("t3_err_pulses", pulses, 32'd1);
        check("t3_no_evt", {31'd0, bus.EVT_VALID}, 32'd0);
        send_byte(8'h1C);
        check("t3_evt", {22'd0, head()}, {22'd0, 10'b00_0001_1100});
        @(negedge CLOCK);

        // 4: overflow while consumer stalled
        bus.EVT_READY = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        check("t4_count", {29'd0, bus.FIFO_COUNT}, 32'd4);
        check("t4_ovf",   {31'd0, bus.OVERFLOW}, 32'd1);
        pop_expect("t4_pop0", {2'b00, 8'h11});
        pop_expect("t4_pop1", {2'b00, 8'h12});
        pop_expect("t4_pop2", {2'b00, 8'h13});
        pop_expect("t4_pop3", {2'b00, 8'h14});
        check("t4_empty",   {29'd0, bus.FIFO_COUNT}, 32'd0);
        check("t4_ovf_held", {31'd0, bus.OVERFLOW}, 32'd1);
        bus.CLR_OVF = 1'b1;
        @(negedge CLOCK);
        bus.CLR_OVF = 1'b0;
        check("t4_ovf_clr", {31'd0, bus.OVERFLOW}, 32'd0);

        // 5: push and pop together while full
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
        check("t5_full", {29'd0, bus.FIFO_COUNT}, 32'd4);
        @(negedge CLOCK);
        bus.RX_DATA    = 8'h16;
        bus.DATA_VALID = 1'b1;
        bus.EVT_READY  = 1'b1;
        @(negedge CLOCK);
        bus.DATA_VALID = 1'b0;
        bus.EVT_READY  = 1'b0;
        check("t5_count", {29'd0, bus.FIFO_COUNT}, 32'd4);
        check("t5_ovf",   {31'd0, bus.OVERFLOW}, 32'd0);
        pop_expect("t5_pop0", {2'b00, 8'h12});
        pop_expect("t5_pop1", {2'b00, 8'h13});
        pop_expect("t5_pop2", {2'b00, 8'h14});
        pop_expect("t5_pop3", {2'b00, 8'h16});
        check("t5_empty", {31'd0, bus.EVT_VALID}, 32'd0);

        // 6: reset drops prefix; double break prefix is an error
        send_byte(8'hE0);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check("t6_rst_count", {29'd0, bus.FIFO_COUNT}, 32'd0);
        send_byte(8'h75);
        check("t6_valid", {31'd0, bus.EVT_VALID}, 32'd1);
        pop_expect("t6_evt", {2'b00, 8'h75});
        send_byte(8'hF0);
        send_byte(8'hF0);
        check("t6_err",    {31'd0, bus.SEQ_ERR}, 32'd1);
        check("t6_no_evt", {31'd0, bus.EVT_VALID}, 32'd0);
        @(negedge CLOCK);
        check("t6_err_pulse", {31'd0, bus.SEQ_ERR}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
